// File: rtl/bus_target_if.sv
// Bundle of the dValid/dAck/data bus, the consumer valid/ready stream and the
// target's status flags; DEPTH sizes the occupancy count.
interface bus_target_if #(
  parameter int DEPTH = 4
);
  logic                     dValid;
  logic [7:0]               data;
  logic                     dAck;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     proto_err;
  logic [1:0]               dbg_state;

  modport slave (
    input  dValid, data, out_ready,
    output dAck, out_valid, out_data, count, overflow, proto_err, dbg_state
  );

  modport master (
    output dValid, data, out_ready,
    input  dAck, out_valid, out_data, count, overflow, proto_err, dbg_state
  );
endinterface

// File: rtl/bus_target.sv
// Target end of the dValid/dAck/data bus: acks each transfer, queues the byte in a
// small FIFO for a valid/ready consumer. Optional master checker: BUS_TARGET_PROTO_CHECK_EN.
module bus_target #(
  parameter int ACK_DELAY = 1,
  parameter int DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  bus_target_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (ACK_DELAY < 1 || ACK_DELAY > 3) begin : g_bad_ack_delay
    $error("bus_target: ACK_DELAY must be in 1..3");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_target: DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t         r_state, w_next;
  logic           r_dvalid_q;
  logic [1:0]     r_w, w_w_next;
  logic           r_ack, w_ack_next;
  logic           r_drop, w_drop_next;
  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [AW:0]    r_count;
  logic           r_overflow;

  logic w_start, w_full, w_pop, w_space, w_push_req, w_push;

  // Stream handshake: a head byte moves to the consumer on a posedge where
  // out_valid && out_ready; out_valid never depends on out_ready.
  assign w_start    = bus.dValid && !r_dvalid_q;
  assign w_full     = (r_count == (AW + 1)'(DEPTH));
  assign w_pop      = (r_count != '0) && bus.out_ready;
  assign w_space    = !w_full || w_pop;
  assign w_push_req = (r_state == S_ACK) && bus.dValid && !r_drop;
  assign w_push     = w_push_req && w_space;

  // The decision for w=0 is taken on the start edge itself so ACK_DELAY=1 is met.
  always_comb begin
    w_next      = r_state;
    w_w_next    = r_w;
    w_ack_next  = 1'b0;
    w_drop_next = r_drop;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_w_next    = 2'd1;
          w_drop_next = 1'b0;
          if (ACK_DELAY <= 1 && w_space) begin
            w_ack_next = 1'b1;
            w_next     = S_ACK;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.dValid) begin
          w_next = S_IDLE;
        end else if ((int'(r_w) + 1 >= ACK_DELAY) && w_space) begin
          w_ack_next = 1'b1;
          w_next     = S_ACK;
        end else if (r_w == 2'd2) begin
          w_ack_next  = 1'b1;
          w_drop_next = 1'b1;
          w_next      = S_ACK;
        end else begin
          w_w_next = r_w + 2'd1;
        end
      end
      S_ACK: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (!bus.dValid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_dvalid_q <= 1'b1;
      r_w        <= '0;
      r_ack      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_dvalid_q <= bus.dValid;
      r_w        <= w_w_next;
      r_ack      <= w_ack_next;
      r_drop     <= w_drop_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if ((r_state == S_ACK && r_drop) || (w_push_req && !w_space)) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= bus.data;
  end

  assign bus.dAck      = r_ack;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = (r_count != '0) ? r_mem[r_rd] : 8'h00;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.dbg_state = r_state;

`ifdef BUS_TARGET_PROTO_CHECK_EN
  logic       r_proto_err;
  logic       r_ack_seen;
  logic [7:0] r_data0;

  // r_ack_seen marks the edge right after dAck was sampled high; the master must be low there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_proto_err <= 1'b0;
      r_ack_seen  <= 1'b0;
      r_data0     <= 8'h00;
    end else begin
      r_ack_seen <= (r_state == S_ACK);
      if (r_state == S_IDLE && w_start) r_data0 <= bus.data;
      if ((r_state == S_WAIT && (!bus.dValid || bus.data != r_data0)) ||
          (r_state == S_ACK && ($isunknown(bus.data) || bus.data != r_data0)) ||
          (r_ack_seen && bus.dValid))
        r_proto_err <= 1'b1;
    end
  end

  assign bus.proto_err = r_proto_err;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: three instances with ACK_DELAY 1, 3 and 2,
// each driven by a simple bus master task, with hand-computed expectations.
module tb_bus_target;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_target_if #(.DEPTH(4)) if_a ();
  bus_target_if #(.DEPTH(4)) if_b ();
  bus_target_if #(.DEPTH(4)) if_c ();

  logic       tb_dv   [3];
  logic [7:0] tb_data [3];
  logic       tb_rdy  [3];

  logic       w_ack  [3];
  logic       w_ov   [3];
  logic [7:0] w_od   [3];
  logic [2:0] w_cnt  [3];
  logic       w_ovf  [3];
  logic       w_perr [3];

  assign if_a.dValid = tb_dv[0];  assign if_a.data = tb_data[0];  assign if_a.out_ready = tb_rdy[0];
  assign if_b.dValid = tb_dv[1];  assign if_b.data = tb_data[1];  assign if_b.out_ready = tb_rdy[1];
  assign if_c.dValid = tb_dv[2];  assign if_c.data = tb_data[2];  assign if_c.out_ready = tb_rdy[2];

  assign w_ack[0] = if_a.dAck; assign w_ov[0] = if_a.out_valid; assign w_od[0] = if_a.out_data;
  assign w_cnt[0] = if_a.count; assign w_ovf[0] = if_a.overflow; assign w_perr[0] = if_a.proto_err;
  assign w_ack[1] = if_b.dAck; assign w_ov[1] = if_b.out_valid; assign w_od[1] = if_b.out_data;
  assign w_cnt[1] = if_b.count; assign w_ovf[1] = if_b.overflow; assign w_perr[1] = if_b.proto_err;
  assign w_ack[2] = if_c.dAck; assign w_ov[2] = if_c.out_valid; assign w_od[2] = if_c.out_data;
  assign w_cnt[2] = if_c.count; assign w_ovf[2] = if_c.overflow; assign w_perr[2] = if_c.proto_err;

  bus_target #(.ACK_DELAY(1), .DEPTH(4)) u_d1 (.clk(clk), .reset(reset), .bus(if_a));
  bus_target #(.ACK_DELAY(3), .DEPTH(4)) u_d3 (.clk(clk), .reset(reset), .bus(if_b));
  bus_target #(.ACK_DELAY(2), .DEPTH(4)) u_d2 (.clk(clk), .reset(reset), .bus(if_c));

`ifdef BUS_TARGET_PROTO_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge. Holds dValid until dAck is seen, drops it one edge later.
  // d_alt replaces the data after T0; rdy_pulse raises out_ready for the T0 edge only.
  task automatic xfer(input int sel, input logic [7:0] d, input logic [7:0] d_alt,
                      input bit rdy_pulse, input int exp_k, input string tag,
                      output logic ov_a, output logic [7:0] od_a);
    int k;
    k = 0;
    tb_data[sel] = d;
    tb_dv[sel]   = 1'b1;
    if (rdy_pulse) tb_rdy[sel] = 1'b1;
    for (int c = 1; c <= 5 && k == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tb_data[sel] = d_alt;
        if (rdy_pulse) tb_rdy[sel] = 1'b0;
      end
      if (w_ack[sel]) k = c;
    end
    check_eq({tag, "_ack_cycle"}, k, exp_k);
    @(negedge clk);
    check_eq({tag, "_ack_width"}, w_ack[sel], 1'b0);
    ov_a = w_ov[sel];
    od_a = w_od[sel];
    tb_dv[sel] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int sel, input string tag);
    tb_rdy[sel] = 1'b1;
    while (exp_q.size() != 0) begin
      check_eq({tag, "_head"}, w_od[sel], exp_q.pop_front());
      @(negedge clk);
    end
    tb_rdy[sel] = 1'b0;
    check_eq({tag, "_empty_count"}, w_cnt[sel], 0);
    check_eq({tag, "_empty_valid"}, w_ov[sel], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ov;
    logic [7:0] od;
    int         n_ack;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tb_dv[i] = 1'b0; tb_data[i] = 8'h00; tb_rdy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_dack",      w_ack[0],  1'b0);
    check_eq("rst_out_valid", w_ov[0],   1'b0);
    check_eq("rst_out_data",  w_od[0],   8'h00);
    check_eq("rst_count",     w_cnt[0],  0);
    check_eq("rst_overflow",  w_ovf[0],  1'b0);
    check_eq("rst_proto_err", w_perr[0], 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // ACK_DELAY=1, empty FIFO, consumer ready
    tb_rdy[0] = 1'b1;
    xfer(0, 8'hA5, 8'hA5, 1'b0, 1, "t1", ov, od);
    check_eq("t1_out_valid", ov, 1'b1);
    check_eq("t1_out_data",  od, 8'hA5);
    check_eq("t1_count_after_pop", w_cnt[0], 0);
    tb_rdy[0] = 1'b0;

    // ACK_DELAY=3, fill to DEPTH, then overflow drop
    for (int i = 1; i <= 4; i++) begin
      xfer(1, 8'(i), 8'(i), 1'b0, 3, "t2_fill", ov, od);
      exp_q.push_back(8'(i));
    end
    check_eq("t2_count_full", w_cnt[1], 4);
    check_eq("t2_no_overflow", w_ovf[1], 1'b0);
    xfer(1, 8'h55, 8'h55, 1'b0, 3, "t2_drop", ov, od);
    check_eq("t2_count_after_drop", w_cnt[1], 4);
    check_eq("t2_overflow", w_ovf[1], 1'b1);
    drain(1, "t2_drain");

    // ACK_DELAY=1 with a full FIFO popped on the decision edge
    for (int i = 1; i <= 4; i++) begin
      xfer(0, 8'(i * 8'h11), 8'(i * 8'h11), 1'b0, 1, "t3_fill", ov, od);
    end
    check_eq("t3_count_full", w_cnt[0], 4);
    xfer(0, 8'h66, 8'h66, 1'b1, 1, "t3_full_pop", ov, od);
    check_eq("t3_count_stays", w_cnt[0], 4);
    check_eq("t3_no_overflow", w_ovf[0], 1'b0);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h66);
    drain(0, "t3_drain");

    // Reset asserted while ACK_DELAY=3 target is waiting
    xfer(1, 8'h77, 8'h77, 1'b0, 3, "t4_pre", ov, od);
    check_eq("t4_pre_count", w_cnt[1], 1);
    tb_data[1] = 8'h88;
    tb_dv[1]   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("t4_rst_dack",     w_ack[1], 1'b0);
    check_eq("t4_rst_count",    w_cnt[1], 0);
    check_eq("t4_rst_valid",    w_ov[1],  1'b0);
    check_eq("t4_rst_overflow", w_ovf[1], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (w_ack[1]) n_ack++;
    end
    check_eq("t4_no_ack_held_valid", n_ack, 0);
    tb_dv[1] = 1'b0;
    @(negedge clk);
    xfer(1, 8'h99, 8'h99, 1'b0, 3, "t4_after", ov, od);
    check_eq("t4_after_count", w_cnt[1], 1);
    check_eq("t4_after_data",  w_od[1],  8'h99);

    // Clean masters leave proto_err low; data change mid-transfer raises it when checked
    check_eq("t5_clean_perr_d1", w_perr[0], 1'b0);
    check_eq("t5_clean_perr_d3", w_perr[1], 1'b0);
    xfer(2, 8'h10, 8'h11, 1'b0, 2, "t5_proto", ov, od);
    check_eq("t5_proto_err", w_perr[2], EXP_PERR);
    check_eq("t5_count",     w_cnt[2],  1);
    check_eq("t5_data",      w_od[2],   8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
